seven_seg_scanner: RTL
======================

// Module: seven_seg_scanner
// PURPOSE
//  Time-multiplexed driver for the board's common-anode 7-segment display.
//  - Consumes the divided scan clock from the seven-segment clock divider; that clock shares the cmosClock domain.
//  - Displays the SD-card readout word as NUM_DIGITS hex digits, one digit lit at a time.
//  - Accepts new words through a valid/ready handshake and swaps them in only at frame boundaries, so no frame is ever torn.
// PARAMETERS
//  NUM_DIGITS    8   digits scanned; digit 0 = rightmost = value[3:0]
//  BLANK_CYCLES  4   cmosClock cycles with all anodes off between digits (anti-ghost); legal range >= 1
//  DIGIT_W       $clog2(NUM_DIGITS)   digit index width (derived, not overridden)
// PORTS
//  cmosClock   in   1              system clock (100 MHz)
//  resetN      in   1              synchronous, active-low reset
//  scanClock   in   1              divided clock from the divider; same domain
//  value       in   4*NUM_DIGITS   hex word to display
//  dpMask      in   NUM_DIGITS     decimal-point enables, 1 = lit; captured with value
//  valueValid  in   1              value/dpMask offered
//  valueReady  out  1              pending slot free; transfer when valueValid & valueReady
//  anode       out  NUM_DIGITS     active-low digit enables
//  segment     out  7              active-low, bit0 = CA ... bit6 = CG
//  dp          out  1              active-low decimal point
//  frameStart  out  1              1-cycle pulse when digit 0 is driven
// BEHAVIOUR
//  - Clock and reset: one clock, cmosClock. resetN is synchronous and active-low; everything is sampled on posedge cmosClock.
//  - Reset values: anode = all 1; segment = 7'h7F; dp = 1; frameStart = 0; valueReady = 1.
//    Internal state after reset: active word = 0, active dp mask = 0, pending empty, digit index = 0, state BLANK, blank counter = 0, scanPrev = 0.
//  - Tick: tick = scanClock & ~scanPrev, where scanPrev is scanClock registered. One tick per divided period.
//  - FSM has two states, BLANK and DRIVE; all outputs are registered.
//    - BLANK: anode = all 1. Blank counter counts up to BLANK_CYCLES-1, then goes to DRIVE. Ticks seen in BLANK are dropped.
//    - DRIVE: anode[idx] = 0, all other anodes = 1; segment = decode(active nibble idx); dp = ~activeDp[idx].
//      On tick: go to BLANK, clear the counter, and advance idx, which wraps NUM_DIGITS-1 -> 0.
//  - Latency: tick seen in cycle t -> anodes off at t+1 -> next digit lit at t+1+BLANK_CYCLES.
//  - After reset the first DRIVE shows digit 0 (value 0, pattern 7'h40) at cycle BLANK_CYCLES.
//  - frameStart pulses in the first DRIVE cycle of idx 0, including the first one after reset.
//  - Handshake:
//    - valueReady = ~pendingFull.
//    - A transfer writes pending and sets pendingFull. valueValid is ignored while valueReady = 0.
//  - Frame swap: in the cycle idx wraps to 0, a full pending is copied into the active word and pendingFull clears, so valueReady = 1 next cycle.
//  - Simultaneous events: a transfer in the wrap cycle (only possible with pending empty) fills pending; no copy is made on that wrap.
//  - Reset mid-frame: drops the pending word and returns to the reset values; no partial digit is shown.
//  - Decode is standard hex 0-F: 0 = 7'h40, 1 = 7'h79, 8 = 7'h00, F = 7'h0E.
// CONFIGURATION
//  LEADING_ZERO_BLANK_EN defined:
//   - Digit i > 0 gets segment = 7'h7F when active nibbles i..NUM_DIGITS-1 are all zero. Digit 0 is always shown.
//   - dp still follows activeDp; anode timing is unchanged.
//  Undefined: every digit is decoded, leading zeros included.
// STRUCTURE
//  Package seven_seg_pkg holds:
//   - SEG_OFF = 7'h7F and the ANODE_OFF fill value;
//   - the state enum {BLANK, DRIVE};
//   - function hexToSegments(4b) -> 7b.
//  Sub-module seven_seg_hex_decoder is a combinational nibble -> segment wrapper around hexToSegments.
//  FSM, handshake and blanking logic stay in this module.
// TESTING
//  T1 reset: hold resetN = 0 for 3 cycles.
//     -> anode = 8'hFF, segment = 7'h7F, valueReady = 1. Digit 0 shows 7'h40 at cycle 4 after release.
//  T2 scan: value = 32'h01234567, one tick every 16 cycles.
//     -> digits 0..7 show 7, 6, 5, 4, 3, 2, 1, 0 in order, each preceded by exactly 4 all-off cycles.
//  T3 handshake: send A, then B immediately; offer C while pending is full.
//     -> A is accepted and valueReady drops; B stalls until A swaps in at the wrap; C is not taken; A is never torn mid-frame.
//  T4 same-cycle transfer: valueValid in the wrap cycle with pending empty.
//     -> no swap this frame; the word becomes active at the next wrap.
//  T5 mid-frame reset: resetN = 0 while idx = 5 and pending is full.
//     -> reset values next cycle; the pending word is lost.
//  T6 option on: value = 32'h00000A05 with LEADING_ZERO_BLANK_EN.
//     -> digits 3..7 = 7'h7F, digit 1 = 7'h40, digit 2 = 'A'. With the macro undefined, all show decoded 0.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared constants, scan state encoding and the hex-to-segment table for the
// multiplexed seven-segment display driver.
package seven_seg_pkg;

  localparam logic [6:0] SEG_OFF   = 7'h7F;
  localparam logic       ANODE_OFF = 1'b1;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  // Active-low segments, bit0 = CA ... bit6 = CG, common-anode display.
  function automatic logic [6:0] hexToSegments(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seven_seg_hex_decoder.sv
// Combinational nibble -> active-low segment pattern.
module seven_seg_hex_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segments
);

  assign segments = hexToSegments(nibble);

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode display driver with frame-aligned word swap.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                    cmosClock,
  input  logic                    resetN,
  input  logic                    scanClock,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dpMask,
  input  logic                    valueValid,
  output logic                    valueReady,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              segment,
  output logic                    dp,
  output logic                    frameStart
);

  localparam int DIGIT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W   = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam int WORD_W  = 4 * NUM_DIGITS;

  // Handshake: a word moves into the pending slot in any cycle where
  // valueValid & valueReady; valueReady is high exactly when the slot is empty.
  scan_state_t           state;
  logic [CNT_W-1:0]      blank_cnt;
  logic [DIGIT_W-1:0]    idx;
  logic                  scan_prev;
  logic                  tick;
  logic                  wrap;
  logic [WORD_W-1:0]     active_word;
  logic [NUM_DIGITS-1:0] active_dp;
  logic [WORD_W-1:0]     pending_word;
  logic [NUM_DIGITS-1:0] pending_dp;
  logic                  pending_full;
  logic [3:0]            nibble;
  logic [6:0]            dec_seg;
  logic [6:0]            next_seg;
  logic [NUM_DIGITS-1:0] digit_sel;

  assign tick       = scanClock & ~scan_prev;
  assign wrap       = (state == DRIVE) && tick && (idx == DIGIT_W'(NUM_DIGITS - 1));
  assign valueReady = ~pending_full;
  assign nibble     = active_word[{idx, 2'b00} +: 4];
  assign digit_sel  = NUM_DIGITS'(1) << idx;

  seven_seg_hex_decoder u_hex_decoder (
    .nibble   (nibble),
    .segments (dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic upper_zero;
  assign upper_zero = ((active_word >> {idx, 2'b00}) == '0);

  always_comb begin
    next_seg = dec_seg;
    if ((idx != '0) && upper_zero) next_seg = SEG_OFF;
  end
`else
  always_comb begin
    next_seg = dec_seg;
  end
`endif

  always_ff @(posedge cmosClock) begin
    if (!resetN) begin
      state        <= BLANK;
      blank_cnt    <= '0;
      idx          <= '0;
      scan_prev    <= 1'b0;
      active_word  <= '0;
      active_dp    <= '0;
      pending_word <= '0;
      pending_dp   <= '0;
      pending_full <= 1'b0;
      anode        <= {NUM_DIGITS{ANODE_OFF}};
      segment      <= SEG_OFF;
      dp           <= 1'b1;
      frameStart   <= 1'b0;
    end else begin
      scan_prev  <= scanClock;
      frameStart <= 1'b0;

      // A wrap only copies a full slot, so a same-cycle offer can only fill an empty one.
      if (wrap && pending_full) begin
        active_word  <= pending_word;
        active_dp    <= pending_dp;
        pending_full <= 1'b0;
      end else if (valueValid && !pending_full) begin
        pending_word <= value;
        pending_dp   <= dpMask;
        pending_full <= 1'b1;
      end

      case (state)
        BLANK: begin
          if (blank_cnt == CNT_W'(BLANK_CYCLES - 1)) begin
            state      <= DRIVE;
            anode      <= ~digit_sel;
            segment    <= next_seg;
            dp         <= ~active_dp[idx];
            frameStart <= (idx == '0);
          end else begin
            blank_cnt <= blank_cnt + CNT_W'(1);
          end
        end
        DRIVE: begin
          if (tick) begin
            state     <= BLANK;
            blank_cnt <= '0;
            anode     <= {NUM_DIGITS{ANODE_OFF}};
            segment   <= SEG_OFF;
            dp        <= 1'b1;
            idx       <= wrap ? '0 : idx + DIGIT_W'(1);
          end
        end
        default: state <= BLANK;
      endcase
    end
  end

endmodule
